// File: rtl/vga_text_pkg.sv
// vga_text_pkg: timing defaults, width helpers and the text cell type
// shared by the text-mode VGA engine and its timing generator.
package vga_text_pkg;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CHAR_BITS = 7;
    localparam int DEF_RGB_W     = 3;

    localparam int DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Bit width able to hold 0..v-1, never narrower than one bit.
    function automatic int w_of(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int total(input int a, input int b,
                                 input int c, input int d);
        return a + b + c + d;
    endfunction

    // One text cell at the default widths.
    typedef struct packed {
        logic [DEF_CHAR_BITS-1:0] ch;
        logic [DEF_RGB_W-1:0]     fg;
        logic [DEF_RGB_W-1:0]     bg;
    } cell_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, x/y raster counters and the raw
// (unregistered) sync, visible and frame-boundary flags.
module vga_timing_gen
    import vga_text_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOT   = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOT   = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = w_of(H_TOT),
    localparam int YW      = w_of(V_TOT)
)(
    input  logic          i_clk,
    input  logic          i_reset,
    output logic          o_tick,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_vis,
    output logic          o_sof,
    output logic          o_eof
);

    localparam int DW = w_of(CLK_DIV);

    logic [DW-1:0] r_div;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_end;
    logic          w_y_end;

    assign o_tick  = (r_div == DW'(CLK_DIV - 1));
    assign w_x_end = (r_x == XW'(H_TOT - 1));
    assign w_y_end = (r_y == YW'(V_TOT - 1));
    assign o_x     = r_x;
    assign o_y     = r_y;

    assign o_hs  = (r_x >= XW'(H_ACTIVE + H_FP)) &&
                   (r_x <  XW'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vs  = (r_y >= YW'(V_ACTIVE + V_FP)) &&
                   (r_y <  YW'(V_ACTIVE + V_FP + V_SYNC));
    assign o_vis = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));
    assign o_sof = (r_x == '0) && (r_y == '0);
    assign o_eof = w_x_end && w_y_end;

    // Divider: one tick every CLK_DIV clocks.
    always_ff @(posedge i_clk) begin
        if (i_reset)     r_div <= '0;
        else if (o_tick) r_div <= '0;
        else             r_div <= r_div + DW'(1);
    end

    // Raster counters, stepped once per tick; y steps on x wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (o_tick) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_text_engine.sv
// vga_text_engine: text-mode VGA with a COLS x ROWS cell buffer and an
// external 1-clk font ROM. Optional cursor blink: define CURSOR_EN.
module vga_text_engine
    import vga_text_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CHAR_W    = 8,
    parameter int   CHAR_H    = 16,
    parameter int   COLS      = 80,
    parameter int   ROWS      = 30,
    parameter int   CHAR_BITS = DEF_CHAR_BITS,
    parameter int   RGB_W     = DEF_RGB_W,
    localparam int  COL_W     = w_of(COLS),
    localparam int  ROW_W     = w_of(ROWS),
    localparam int  LW        = w_of(CHAR_H),
    localparam int  RA_W      = CHAR_BITS + LW
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [COL_W-1:0]     wr_col,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic [CHAR_BITS-1:0] wr_char,
    input  logic [RGB_W-1:0]     wr_fg,
    input  logic [RGB_W-1:0]     wr_bg,
    input  logic [COL_W-1:0]     cursor_col,
    input  logic [ROW_W-1:0]     cursor_row,
    output logic [RA_W-1:0]      rom_addr,
    input  logic [CHAR_W-1:0]    font_word,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic [RGB_W-1:0]     rgb,
    output logic                 frame_start
);

    localparam int H_TOT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int XW    = w_of(H_TOT);
    localparam int YW    = w_of(V_TOT);
    localparam int CXS   = $clog2(CHAR_W);
    localparam int CYS   = $clog2(CHAR_H);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = w_of(CELLS);

    typedef struct packed {
        logic [CHAR_BITS-1:0] ch;
        logic [RGB_W-1:0]     fg;
        logic [RGB_W-1:0]     bg;
    } tcell_t;

    tcell_t           r_ram [CELLS];
    tcell_t           r_cell;
    logic             r_cur;
    logic [RGB_W-1:0] r_fg;
    logic [RGB_W-1:0] r_bg;
    logic [RA_W-1:0]  r_rom_addr;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic [RGB_W-1:0] r_rgb;
    logic             r_frame_start;

    logic             w_tick;
    logic [XW-1:0]    w_x;
    logic [YW-1:0]    w_y;
    logic             w_hs;
    logic             w_vs;
    logic             w_vis;
    logic             w_sof;
    logic             w_eof;
    logic [XW-1:0]    w_col;
    logic [YW-1:0]    w_row;
    logic             w_in_text;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_wr_addr;
    logic             w_wr_ok;
    logic             w_cur_hit;
    logic [LW-1:0]    w_line;
    logic [CXS-1:0]   w_bit_idx;
    logic             w_px;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .i_clk  (clk),
        .i_reset(reset),
        .o_tick (w_tick),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_hs   (w_hs),
        .o_vs   (w_vs),
        .o_vis  (w_vis),
        .o_sof  (w_sof),
        .o_eof  (w_eof)
    );

    assign w_col     = w_x >> CXS;
    assign w_row     = w_y >> CYS;
    assign w_in_text = (w_col < XW'(COLS)) && (w_row < YW'(ROWS));
    assign w_line    = w_y[LW-1:0];
    assign w_bit_idx = ~w_x[CXS-1:0];
    assign w_px      = font_word[w_bit_idx];

    // Outside the text area the read address is parked on cell 0.
    assign w_rd_addr = w_in_text ?
        AW'(w_row) * AW'(COLS) + AW'(w_col) : '0;

    assign w_wr_ok = wr_en &&
        ({1'b0, wr_col} < (COL_W + 1)'(COLS)) &&
        ({1'b0, wr_row} < (ROW_W + 1)'(ROWS));
    assign w_wr_addr = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

`ifdef CURSOR_EN
    logic [4:0] r_frame_cnt;

    // Frame counter for blinking; its MSB is the blink phase.
    always_ff @(posedge clk) begin
        if (reset)
            r_frame_cnt <= '0;
        else if (w_tick && w_eof)
            r_frame_cnt <= r_frame_cnt + 5'd1;
    end

    assign w_cur_hit = r_frame_cnt[4] && w_in_text &&
                       (w_col == XW'(cursor_col)) &&
                       (w_row == YW'(cursor_row));
`else
    logic w_unused;
    assign w_unused  = ^{cursor_col, cursor_row, w_eof};
    assign w_cur_hit = 1'b0;
`endif

    // Text RAM: read-first, so a same-clk write shows the old cell.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_ram[w_wr_addr] <= {wr_char, wr_fg, wr_bg};
        r_cell <= r_ram[w_rd_addr];
        r_cur  <= w_cur_hit;
    end

    // Font address and (cursor-swapped) colours, one clk after the read.
    always_ff @(posedge clk) begin
        if (reset)
            r_rom_addr <= '0;
        else
            r_rom_addr <= {r_cell.ch, w_line};
        r_fg <= r_cur ? r_cell.bg : r_cell.fg;
        r_bg <= r_cur ? r_cell.fg : r_cell.bg;
    end

    // Pin register: sync, visibility and colour load on the same tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_hsync       <= w_hs ? SYNC_POL : ~SYNC_POL;
                r_vsync       <= w_vs ? SYNC_POL : ~SYNC_POL;
                r_video_on    <= w_vis;
                r_rgb         <= (w_vis && w_in_text) ?
                                 (w_px ? r_fg : r_bg) : '0;
                r_frame_start <= w_sof;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_text_engine.sv
// tb_vga_text_engine: directed checks of the text engine on a small
// raster (32x37 ticks, 3x2 cells) with a behavioural font ROM.
module tb_vga_text_engine;

    localparam int CLK_DIV = 4;
    localparam int HA = 25, HFP = 2, HS = 4, HBP = 1;
    localparam int VA = 33, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_col;
    logic [0:0]  wr_row;
    logic [6:0]  wr_char;
    logic [2:0]  wr_fg;
    logic [2:0]  wr_bg;
    logic [1:0]  cursor_col;
    logic [0:0]  cursor_row;
    logic [10:0] rom_addr;
    logic [7:0]  font_word;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [2:0]  rgb;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    vga_text_engine #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .SYNC_POL (1'b0),
        .CHAR_W   (8),
        .CHAR_H   (16),
        .COLS     (3),
        .ROWS     (2),
        .CHAR_BITS(7),
        .RGB_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_char    (wr_char),
        .wr_fg      (wr_fg),
        .wr_bg      (wr_bg),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rom_addr   (rom_addr),
        .font_word  (font_word),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .rgb        (rgb),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Font ROM: 0x41 = leftmost pixel, 0x42 = rightmost, else solid.
    always @(posedge clk) begin
        case (rom_addr[10:4])
            7'h41:   font_word <= 8'h80;
            7'h42:   font_word <= 8'h01;
            default: font_word <= 8'hFF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_cell(input logic [1:0] c, input logic [0:0] r,
                              input logic [6:0] ch,
                              input logic [2:0] fg, input logic [2:0] bg);
        @(negedge clk);
        wr_col  = c;
        wr_row  = r;
        wr_char = ch;
        wr_fg   = fg;
        wr_bg   = bg;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sync_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("frame_sync", frame_start, 1'b1);
    endtask

    task automatic advance(input int pix);
        repeat (pix * CLK_DIV) @(negedge clk);
    endtask

    task automatic goto_pix(input int x, input int y);
        sync_frame();
        advance(y * HT + x);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_hs"},  hsync, 1'b1);
        check({tag, "_vs"},  vsync, 1'b1);
        check({tag, "_von"}, video_on, 1'b0);
        check({tag, "_rgb"}, rgb, 3'd0);
        check({tag, "_fs"},  frame_start, 1'b0);
        check({tag, "_ra"},  rom_addr, 11'd0);
    endtask

    initial begin
        int n;
        int hs_lo, vs_lo, vis, fs;
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_col     = '0;
        wr_row     = '0;
        wr_char    = '0;
        wr_fg      = '0;
        wr_bg      = '0;
        cursor_col = 2'd0;
        cursor_row = 1'd0;

        // Reset held 10 clks.
        repeat (10) @(negedge clk);
        check_reset_outs("rst");

        // Release: first pixel one tick later.
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 50);
        check("fs_latency", n, CLK_DIV);
        check("p00_von", video_on, 1'b1);
        check("p00_hs", hsync, 1'b1);

        // Free run one whole frame, sampling once per pixel.
        hs_lo = 0;
        vs_lo = 0;
        vis   = 0;
        fs    = 0;
        for (int i = 0; i < FT; i++) begin
            if (!hsync)     hs_lo++;
            if (!vsync)     vs_lo++;
            if (video_on)   vis++;
            if (frame_start) fs++;
            advance(1);
        end
        check("hs_low_cnt", hs_lo, VT * HS);
        check("vs_low_cnt", vs_lo, VS * HT);
        check("vis_cnt", vis, VA * HA);
        check("fs_cnt", fs, 1);
        check("fs_period", frame_start, 1'b1);

        // Cell (0,0) = 'A' fg 7 bg 1.
        write_cell(2'd0, 1'd0, 7'h41, 3'd7, 3'd1);
        goto_pix(0, 0);
        check("a_p00_rgb", rgb, 3'd7);
        check("a_p00_ra", rom_addr, {7'h41, 4'd0});
        advance(1);
        check("a_p10_rgb", rgb, 3'd1);
        advance(HT - 1);
        check("a_p01_rgb", rgb, 3'd7);
        check("a_p01_ra", rom_addr, {7'h41, 4'd1});

        // In-range cell (0,1), dropped col=COLS write, last cell (2,1).
        write_cell(2'd0, 1'd1, 7'h43, 3'd3, 3'd0);
        write_cell(2'd3, 1'd0, 7'h41, 3'd6, 3'd5);
        write_cell(2'd2, 1'd1, 7'h42, 3'd2, 3'd4);
        goto_pix(24, 0);
        check("gap_x24_rgb", rgb, 3'd0);
        check("gap_x24_von", video_on, 1'b1);
        advance(16 * HT - 24);
        check("drop_p016_rgb", rgb, 3'd3);
        advance(16);
        check("last_p1616_rgb", rgb, 3'd4);
        advance(7);
        check("last_p2316_rgb", rgb, 3'd2);
        advance(1);
        check("gap_p2416_rgb", rgb, 3'd0);
        check("gap_p2416_von", video_on, 1'b1);
        advance(1);
        check("hbl_p2516_von", video_on, 1'b0);
        check("hbl_p2516_rgb", rgb, 3'd0);
        advance(2);
        check("hsync_p2716", hsync, 1'b0);
        goto_pix(0, 32);
        check("gap_y32_rgb", rgb, 3'd0);
        check("gap_y32_von", video_on, 1'b1);

        // Reset asserted mid-line.
        goto_pix(17, 16);
        check("pre_rst_rgb", rgb, 3'd4);
        check("pre_rst_ra", rom_addr, {7'h42, 4'd0});
        reset = 1'b1;
        @(negedge clk);
        check_reset_outs("mid");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 50);
        check("re_fs_latency", n, CLK_DIV);
        check("re_p00_rgb", rgb, 3'd7);
        check("re_p00_ra", rom_addr, {7'h41, 4'd0});

`ifdef CURSOR_EN
        // Cursor on (0,0): normal in frame 15, swapped in frame 16.
        repeat (15) sync_frame();
        check("cur_f15_rgb", rgb, 3'd7);
        sync_frame();
        check("cur_f16_rgb", rgb, 3'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
